// File: rtl/pll_rst_pkg.sv
// Shared types for the PLL reset/lock sequencer.
// Holds the sequencer state encoding and a small saturating-count helper.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Flops clear to 0 on rst_n.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// rPLL reset/lock handshake controller on the reference clock.
// Drives PLL RESET, qualifies LOCK, gates the downstream reset.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       force_relock,
  input  logic       clr_err,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       lock_lost,
  output logic [7:0] retry_cnt,
  output logic       timeout_err
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STB_MAX  = SW'(STABLE_CYCLES);

  state_t          state_q;
  state_t          state_d;
  logic [RW-1:0]   rst_cnt_q;
  logic [RW-1:0]   rst_cnt_d;
  logic [TW-1:0]   tmo_cnt_q;
  logic [TW-1:0]   tmo_cnt_d;
  logic [SW-1:0]   stb_cnt_q;
  logic [SW-1:0]   stb_cnt_d;
  logic [7:0]      retry_d;
  logic [7:0]      retry_inc;
  logic            lock_s;
  logic            tmo_hit;
  logic            lost_d;
  logic            err_set;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);
  assign retry_inc = sat_inc8(retry_cnt);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    stb_cnt_d = stb_cnt_q;
    retry_d   = retry_cnt;
    lost_d    = 1'b0;
    err_set   = 1'b0;

    unique case (state_q)
      RESET_PLL: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          rst_cnt_d = '0;
          tmo_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      WAIT_LOCK: begin
        if (!tmo_hit) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        if (tmo_hit) begin
          retry_d = retry_inc;
          if (MAX_RETRY != 0 && retry_inc == 8'(MAX_RETRY)) begin
            state_d = FAIL;
            err_set = 1'b1;
          end else begin
            state_d   = RESET_PLL;
            rst_cnt_d = '0;
          end
        end else if (lock_s) begin
          stb_cnt_d = SW'(1);
          state_d   = (STABLE_CYCLES == 1) ? RUN : STABLE;
        end
      end

      // tmo_cnt is never cleared here so a flapping lock still times out
      STABLE: begin
        if (!tmo_hit) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        if (tmo_hit) begin
          retry_d = retry_inc;
          if (MAX_RETRY != 0 && retry_inc == 8'(MAX_RETRY)) begin
            state_d = FAIL;
            err_set = 1'b1;
          end else begin
            state_d   = RESET_PLL;
            rst_cnt_d = '0;
          end
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else begin
          if (stb_cnt_q == STB_LAST) begin
            state_d = RUN;
          end
          if (stb_cnt_q != STB_MAX) begin
            stb_cnt_d = stb_cnt_q + SW'(1);
          end
        end
      end

      RUN: begin
        if (!lock_s) begin
          lost_d    = 1'b1;
          state_d   = RESET_PLL;
          rst_cnt_d = '0;
        end
      end

      FAIL: begin
        state_d = FAIL;
      end

      default: begin
        state_d   = RESET_PLL;
        rst_cnt_d = '0;
      end
    endcase

    if (state_d == RUN && state_q != RUN) begin
      retry_d = '0;
    end

    if (force_relock) begin
      state_d   = RESET_PLL;
      rst_cnt_d = '0;
      err_set   = 1'b0;
      retry_d   = (state_q == FAIL) ? 8'd0 : retry_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      retry_cnt   <= '0;
      pll_reset   <= 1'b1;
      sys_rst_n   <= 1'b0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_cnt   <= retry_d;
      pll_reset   <= (state_d == RESET_PLL) || (state_d == FAIL);
      sys_rst_n   <= (state_d == RUN);
      locked      <= (state_d == RUN);
      lock_lost   <= lost_d;
      timeout_err <= err_set | (timeout_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pll_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       force_relock = 1'b0;
  logic       clr_err = 1'b0;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       locked;
  logic       lock_lost;
  logic [7:0] retry_cnt;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .SYNC_STAGES   (2),
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .force_relock (force_relock),
    .clr_err      (clr_err),
    .pll_reset    (pll_reset),
    .sys_rst_n    (sys_rst_n),
    .locked       (locked),
    .lock_lost    (lock_lost),
    .retry_cnt    (retry_cnt),
    .timeout_err  (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks_until_rst(input logic val, output int n);
    n = 0;
    while (pll_reset !== val && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0 ||
        lock_lost !== 1'b0 || retry_cnt !== 8'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got rst=%b srst=%b lk=%b lost=%b rc=%0d err=%b, want 1 0 0 0 0 0",
               pll_reset, sys_rst_n, locked, lock_lost, retry_cnt, timeout_err);
    end
  endtask

  task automatic test_clean_lock();
    int n;
    rst_n = 1'b1;
    ticks_until_rst(1'b0, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL clean_rst_width: got %0d cycles, want 4", n);
    end
    repeat (10) tick();
    checks++;
    if (pll_reset !== 1'b0 || sys_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL clean_wait: got rst=%b srst=%b, want 0 0", pll_reset, sys_rst_n);
    end
    pll_lock = 1'b1;
    repeat (9) tick();
    checks++;
    if (sys_rst_n !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL clean_no_early: got srst=%b lk=%b at edge 9, want 0 0", sys_rst_n, locked);
    end
    tick();
    checks++;
    if (sys_rst_n !== 1'b1 || locked !== 1'b1 || retry_cnt !== 8'd0 || pll_reset !== 1'b0) begin
      errors++;
      $display("FAIL clean_release: got srst=%b lk=%b rc=%0d rst=%b, want 1 1 0 0",
               sys_rst_n, locked, retry_cnt, pll_reset);
    end
  endtask

  task automatic test_glitch();
    int n;
    pll_lock = 1'b0;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    checks++;
    if (lock_lost !== 1'b0 || sys_rst_n !== 1'b0 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL glitch_force: got lost=%b srst=%b rst=%b, want 0 0 1", lock_lost, sys_rst_n, pll_reset);
    end
    ticks_until_rst(1'b0, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL glitch_rst_width: got %0d cycles, want 4", n);
    end
    repeat (2) tick();
    pll_lock = 1'b1;
    repeat (5) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (9) tick();
    checks++;
    if (sys_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_early: got srst=%b at edge 9 after rise, want 0", sys_rst_n);
    end
    tick();
    checks++;
    if (sys_rst_n !== 1'b1 || locked !== 1'b1 || retry_cnt !== 8'd0) begin
      errors++;
      $display("FAIL glitch_release: got srst=%b lk=%b rc=%0d, want 1 1 0", sys_rst_n, locked, retry_cnt);
    end
  endtask

  task automatic test_timeout_fail();
    int n;
    pll_lock = 1'b0;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    for (int a = 1; a <= 3; a++) begin
      ticks_until_rst(1'b0, n);
      checks++;
      if (n !== 4) begin
        errors++;
        $display("FAIL tmo_rst_width: attempt %0d got %0d cycles, want 4", a, n);
      end
      n = 0;
      while (pll_reset === 1'b0 && n < 100) begin
        if (a == 3 && n == 31) clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n++;
      end
      checks++;
      if (n !== 32 || retry_cnt !== 8'(a) || timeout_err !== (a == 3)) begin
        errors++;
        $display("FAIL tmo_attempt: attempt %0d got len=%0d rc=%0d err=%b, want 32 %0d %b",
                 a, n, retry_cnt, timeout_err, a, (a == 3));
      end
    end
    repeat (40) tick();
    checks++;
    if (pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || timeout_err !== 1'b1 || retry_cnt !== 8'd3) begin
      errors++;
      $display("FAIL fail_hold: got rst=%b srst=%b err=%b rc=%0d, want 1 0 1 3",
               pll_reset, sys_rst_n, timeout_err, retry_cnt);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL clr_err: got err=%b rst=%b, want 0 1", timeout_err, pll_reset);
    end
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    checks++;
    if (retry_cnt !== 8'd0 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL relock_from_fail: got rc=%0d rst=%b, want 0 1", retry_cnt, pll_reset);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    int pulses;
    ticks_until_rst(1'b0, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL relock_rst_width: got %0d cycles, want 4", n);
    end
    pll_lock = 1'b1;
    repeat (10) tick();
    checks++;
    if (locked !== 1'b1 || sys_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL relock_release: got lk=%b srst=%b, want 1 1", locked, sys_rst_n);
    end
    pll_lock = 1'b0;
    repeat (2) tick();
    checks++;
    if (lock_lost !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_latency: got lost=%b lk=%b, want 0 1", lock_lost, locked);
    end
    tick();
    checks++;
    if (lock_lost !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL loss_pulse: got lost=%b srst=%b lk=%b rst=%b, want 1 0 0 1",
               lock_lost, sys_rst_n, locked, pll_reset);
    end
    pulses = 0;
    n = 0;
    while (pll_reset === 1'b1 && n < 100) begin
      tick();
      n++;
      if (lock_lost === 1'b1) pulses++;
    end
    checks++;
    if (n !== 4 || pulses !== 0) begin
      errors++;
      $display("FAIL loss_resequence: got width=%0d extra_pulses=%0d, want 4 0", n, pulses);
    end
    repeat (3) tick();
    pll_lock = 1'b1;
    repeat (9) tick();
    checks++;
    if (sys_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL loss_relock_early: got srst=%b, want 0", sys_rst_n);
    end
    tick();
    checks++;
    if (sys_rst_n !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_relock: got srst=%b lk=%b, want 1 1", sys_rst_n, locked);
    end
  endtask

  task automatic test_flapping();
    int n;
    int runs;
    pll_lock = 1'b0;
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    ticks_until_rst(1'b0, n);
    n = 0;
    runs = 0;
    while (pll_reset === 1'b0 && n < 100) begin
      pll_lock = (((n / 4) % 2) == 0) ? 1'b1 : 1'b0;
      tick();
      n++;
      if (sys_rst_n === 1'b1) runs++;
    end
    checks++;
    if (n !== 32 || runs !== 0 || retry_cnt !== 8'd1) begin
      errors++;
      $display("FAIL flap_timeout: got len=%0d run_cycles=%0d rc=%0d, want 32 0 1", n, runs, retry_cnt);
    end
  endtask

  task automatic test_rst_mid_stable();
    int n;
    pll_lock = 1'b0;
    ticks_until_rst(1'b0, n);
    pll_lock = 1'b1;
    repeat (5) tick();
    checks++;
    if (pll_reset !== 1'b0 || sys_rst_n !== 1'b0 || retry_cnt !== 8'd1) begin
      errors++;
      $display("FAIL mid_stable_state: got rst=%b srst=%b rc=%0d, want 0 0 1", pll_reset, sys_rst_n, retry_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0 ||
        lock_lost !== 1'b0 || retry_cnt !== 8'd0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rst=%b srst=%b lk=%b lost=%b rc=%0d err=%b, want 1 0 0 0 0 0",
               pll_reset, sys_rst_n, locked, lock_lost, retry_cnt, timeout_err);
    end
    tick();
    rst_n = 1'b1;
    n = 0;
    while (locked !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 12 || retry_cnt !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_release: got %0d cycles rc=%0d, want 12 0", n, retry_cnt);
    end
  endtask

  task automatic test_force_and_loss();
    int n;
    int pulses;
    pll_lock = 1'b0;
    repeat (2) tick();
    force_relock = 1'b1;
    tick();
    force_relock = 1'b0;
    checks++;
    if (lock_lost !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL force_loss_pulse: got lost=%b srst=%b lk=%b rst=%b, want 1 0 0 1",
               lock_lost, sys_rst_n, locked, pll_reset);
    end
    pulses = 0;
    n = 0;
    while (pll_reset === 1'b1 && n < 100) begin
      tick();
      n++;
      if (lock_lost === 1'b1) pulses++;
    end
    checks++;
    if (n !== 4 || pulses !== 0) begin
      errors++;
      $display("FAIL force_loss_once: got width=%0d extra_pulses=%0d, want 4 0", n, pulses);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_glitch();
    test_timeout_fail();
    test_lock_loss();
    test_flapping();
    test_rst_mid_stable();
    test_force_and_loss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
